// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage and imem.
// Latency: none (wires only); the response may come in the request cycle or later.
// Backpressure: imem_req and imem_addr stay stable until imem_valid returns.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem and loads the IF/ID register; `FETCH_PERF_EN adds perf counters.
// Latency: 1 cycle from imem_valid to IF/ID with a combinational memory; variable otherwise.
// Backpressure: stall holds IF/ID and PC; a response that lands during a stall is held in a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          pc,
    output logic [31:0]          instr_p,
    output logic [31:0]          pc_p,
    output logic                 valid_p
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] drain_addr;
    logic [31:0] buf_dat;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;
    logic        deliver;
    logic [31:0] deliver_dat;
    logic        load_buf;
    logic        start_drain;

    // Redirect targets are word aligned; the low two bits are masked off.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc       = pc + 32'd4;

    // While draining, the old address stays on the bus until its stale response returns.
    assign imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr : pc;

    // Next-state and per-cycle fetch decisions; redirect outranks stall and fetch progress.
    always_comb begin
        state_d     = state_q;
        deliver     = 1'b0;
        deliver_dat = buf_dat;
        load_buf    = 1'b0;
        start_drain = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (imem.imem_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d     = DRAIN;
                        start_drain = 1'b1;
                    end
                end else if (imem.imem_valid) begin
                    if (stall) begin
                        state_d  = HOLD;
                        load_buf = 1'b1;
                    end else begin
                        deliver     = 1'b1;
                        deliver_dat = imem.imem_rdata;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (!stall) begin
                    deliver     = 1'b1;
                    deliver_dat = buf_dat;
                    state_d     = REQ;
                end
            end
            DRAIN: begin
                if (imem.imem_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC advances only when an instruction is handed to IF/ID; redirect overrides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_tgt;
        end else if (deliver) begin
            pc <= pc_inc;
        end
    end

    // Remember the outstanding address so the stale response can be drained after a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_addr <= 32'd0;
        end else if (start_drain) begin
            drain_addr <= pc;
        end
    end

    // Skid buffer: only the word is kept, its address is the held PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_dat <= 32'd0;
        end else if (redirect) begin
            buf_dat <= 32'd0;
        end else if (load_buf) begin
            buf_dat <= imem.imem_rdata;
        end
    end

    // IF/ID register: flush wins, stall holds, otherwise load or insert a bubble keeping pc_p.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_p <= NOP_INSTR;
            pc_p    <= 32'd0;
            valid_p <= 1'b0;
        end else if (flush) begin
            instr_p <= NOP_INSTR;
            valid_p <= 1'b0;
        end else if (!stall) begin
            if (deliver) begin
                instr_p <= deliver_dat;
                pc_p    <= pc;
                valid_p <= 1'b1;
            end else begin
                instr_p <= NOP_INSTR;
                valid_p <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Free-running counters of real IF/ID loads and of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (deliver && !flush) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control and memory latency.
// A flag-level reference model predicts all outputs and is compared every cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc;
    logic [31:0] instr_p;
    logic [31:0] pc_p;
    logic        valid_p;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .pc          (pc),
        .instr_p     (instr_p),
        .pc_p        (pc_p),
        .valid_p     (valid_p)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_ppc, m_drain_addr, m_buf;
    bit          m_vld, m_started, m_holding, m_draining;
    logic [31:0] m_fetched, m_stalls;

    // memory model state
    int          mem_lat = 0;
    bit          mem_pending = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr_hold = 32'd0;
    bit          force_valid = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = NOP; m_ppc = 32'd0; m_vld = 0;
        m_started = 0; m_holding = 0; m_draining = 0;
        m_drain_addr = 32'd0; m_buf = 32'd0;
        m_fetched = 32'd0; m_stalls = 32'd0;
        mem_pending = 0; mem_wait = 0;
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = m_started && !m_holding;
        check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
        if (exp_req)
            check("imem_addr", imem_bus.imem_addr, m_draining ? m_drain_addr : m_pc);
        check("pc", pc, m_pc);
        check("instr_p", instr_p, m_instr);
        check("pc_p", pc_p, m_ppc);
        check("valid_p", {31'd0, valid_p}, {31'd0, m_vld});
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stalls);
`endif
    endtask

    // Memory: one response per request, mem_lat cycles after it first appears; address must not move.
    task automatic mem_drive(output bit v, output logic [31:0] rd);
        v  = 0;
        rd = $urandom;
        if (force_valid) begin
            v = 1;
            rd = 32'hBAD0_BAD0;
            force_valid = 0;
        end else if (imem_bus.imem_req) begin
            if (!mem_pending) begin
                mem_pending = 1;
                mem_wait = mem_lat;
                mem_addr_hold = imem_bus.imem_addr;
            end else begin
                check("addr_stable", imem_bus.imem_addr, mem_addr_hold);
            end
            if (mem_wait == 0) begin
                v = 1;
                rd = word_at(mem_addr_hold);
                mem_pending = 0;
            end else begin
                mem_wait--;
            end
        end
    endtask

    // What one clock edge must do, stated in terms of the fetch rules.
    task automatic model_update(input bit s, input bit f, input bit r, input logic [31:0] rpc,
                                input bit v, input logic [31:0] rd);
        bit fresh, deliver;
        logic [31:0] dword;
        fresh = m_started && !m_holding && !m_draining && v;
        deliver = 0;
        dword = 32'd0;
        if (!r) begin
            if (m_holding && !s) begin deliver = 1; dword = m_buf; end
            else if (fresh && !s) begin deliver = 1; dword = rd; end
        end
        if (m_draining) begin
            if (v) m_draining = 0;
        end else if (r && m_started && !m_holding && !v) begin
            m_draining = 1;
            m_drain_addr = m_pc;
        end
        if (!r && fresh && s) begin
            m_holding = 1;
            m_buf = rd;
        end else if (r || deliver) begin
            m_holding = 0;
        end
        if (f) begin
            m_instr = NOP; m_vld = 0;
        end else if (!s) begin
            if (deliver) begin m_instr = dword; m_ppc = m_pc; m_vld = 1; end
            else begin m_instr = NOP; m_vld = 0; end
        end
        if (r) m_pc = rpc & 32'hFFFF_FFFC;
        else if (deliver) m_pc = m_pc + 32'd4;
        m_started = 1;
        if (s) m_stalls = m_stalls + 32'd1;
        if (deliver && !f) m_fetched = m_fetched + 32'd1;
    endtask

    // One cycle: check model vs DUT, drive inputs and memory at negedge, advance past posedge.
    task automatic step(input bit s, input bit f, input bit r, input logic [31:0] rpc);
        bit v;
        logic [31:0] rd;
        @(negedge clk);
        compare_all();
        mem_drive(v, rd);
        stall = s; flush = f; redirect = r; redirect_pc = rpc;
        imem_bus.imem_valid = v;
        imem_bus.imem_rdata = rd;
        model_update(s, f, r, rpc, v, rd);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset from mid-cycle, released just after a rising edge.
    task automatic async_reset();
        #2;
        reset = 1;
        stall = 0; flush = 0; redirect = 0;
        imem_bus.imem_valid = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        imem_bus.imem_valid = 0;
        imem_bus.imem_rdata = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        // reset values
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr_p, NOP);
        check("rst_pc_p", pc_p, 32'h0);
        check("rst_valid", {31'd0, valid_p}, 32'd0);
        check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 0;

        // 1: zero-latency fetch stream 0,4,8
        mem_lat = 0;
        step(0, 0, 0, 0);
        check("t1_addr0", imem_bus.imem_addr, 32'h0);
        check("t1_req", {31'd0, imem_bus.imem_req}, 32'd1);
        step(0, 0, 0, 0);
        check("t1_addr4", imem_bus.imem_addr, 32'h4);
        check("t1_instr0", instr_p, 32'hDEAD_0000);
        check("t1_valid", {31'd0, valid_p}, 32'd1);
        step(0, 0, 0, 0);
        check("t1_addr8", imem_bus.imem_addr, 32'h8);
        check("t1_pc_p4", pc_p, 32'h4);

        // 2: three-cycle latency at 0x4
        async_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        mem_lat = 2;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0);
            check("t2_addr_hold", imem_bus.imem_addr, 32'h4);
            check("t2_bubble", {31'd0, valid_p}, 32'd0);
        end
        step(0, 0, 0, 0);
        check("t2_instr", instr_p, 32'hDEAD_0004);
        check("t2_pc_p", pc_p, 32'h4);
        check("t2_addr8", imem_bus.imem_addr, 32'h8);

        // 3: response at 0x8 under a two-cycle stall
        mem_lat = 0;
        step(1, 0, 0, 0);
        check("t3_hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("t3_hold_instr", instr_p, 32'hDEAD_0004);
        step(1, 0, 0, 0);
        check("t3_hold_pc_p", pc_p, 32'h4);
        step(0, 0, 0, 0);
        check("t3_instr", instr_p, 32'hDEAD_0008);
        check("t3_pc_p", pc_p, 32'h8);
        check("t3_addr", imem_bus.imem_addr, 32'hC);

        // 4: redirect+flush to 0x103 with request to 0xC outstanding
        mem_lat = 2;
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h103);
        check("t4_drain_addr", imem_bus.imem_addr, 32'hC);
        check("t4_pc", pc, 32'h100);
        check("t4_flush_instr", instr_p, NOP);
        step(0, 0, 0, 0);
        check("t4_new_addr", imem_bus.imem_addr, 32'h100);
        check("t4_valid", {31'd0, valid_p}, 32'd0);
        mem_lat = 0;
        step(0, 0, 0, 0);
        check("t4_instr", instr_p, 32'hDEAD_0100);

        // 5: PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFE);
        check("t5_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("t5_wrap", imem_bus.imem_addr, 32'h0);
        check("t5_instr", instr_p, 32'h2152_FFFC);

        // 6: reset while draining, late response ignored
        mem_lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        check("t6_drain", imem_bus.imem_addr, 32'h0);
        check("t6_pc", pc, 32'h40);
        #2;
        reset = 1;
        model_reset();
        #1;
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("t6_rst_instr", instr_p, NOP);
        @(posedge clk);
        #1;
        reset = 0;
        force_valid = 1;
        step(0, 0, 0, 0);
        check("t6_restart", imem_bus.imem_addr, 32'h0);
        check("t6_no_load", {31'd0, valid_p}, 32'd0);
        mem_lat = 0;
        step(0, 0, 0, 0);
        check("t6_instr", instr_p, 32'hDEAD_0000);

        // randomized control and latency
        for (int n = 0; n < 4000; n++) begin
            bit s, f, r;
            logic [31:0] rpc;
            if ($urandom_range(0, 399) == 0) async_reset();
            mem_lat = $urandom_range(0, 3);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(s, f, r, rpc);
        end
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
